// File: rtl/miner_dispatcher.sv
// miner_dispatcher: splits one mining job's nonce range across NUM_CORES
// bitcoin_miner cores and starts them together. It returns the first winning
// nonce, a not-found result, an abort or a range error. The cores have no stop
// input, so every core is drained before the next job is accepted.
module miner_dispatcher #(
  parameter int NUM_CORES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  // host job interface
  input  logic                      i_job_valid,
  output logic                      o_job_ready,
  input  logic [255:0]              i_job_first_hash,
  input  logic [127:0]              i_job_second_block,
  input  logic [255:0]              i_job_target,
  input  logic [31:0]               i_job_nonce_lo,
  input  logic [31:0]               i_job_nonce_hi,
  input  logic                      i_abort,
  // miner core array
  output logic [NUM_CORES-1:0]      o_core_start,
  output logic [255:0]              o_core_first_hash,
  output logic [255:0]              o_core_target,
  output logic [NUM_CORES*128-1:0]  o_core_second_block,
  output logic [NUM_CORES*32-1:0]   o_core_max_nonce,
  input  logic [NUM_CORES-1:0]      i_core_running,
  input  logic [NUM_CORES-1:0]      i_core_found,
  input  logic [NUM_CORES*32-1:0]   i_core_nonce,
  // host result interface
  output logic                      o_result_valid,
  input  logic                      i_result_ready,
  output logic                      o_result_found,
  output logic                      o_result_aborted,
  output logic                      o_result_error,
  output logic [31:0]               o_result_nonce,
  output logic [31:0]               o_result_cycles
);

  localparam int         LOG2_CORES = $clog2(NUM_CORES);
  localparam logic [32:0] CORES_33  = 33'(NUM_CORES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_RUN,
    S_REPORT,
    S_DRAIN
  } state_t;

  state_t                     r_state;
  logic [NUM_CORES-1:0]       r_used;
  logic [31:0]                r_hi;
  logic [NUM_CORES-1:0]       r_core_start;
  logic [255:0]               r_core_first_hash;
  logic [255:0]               r_core_target;
  logic [NUM_CORES*128-1:0]   r_core_second_block;
  logic [NUM_CORES*32-1:0]    r_core_max_nonce;
  logic                       r_result_valid;
  logic                       r_result_found;
  logic                       r_result_aborted;
  logic                       r_result_error;
  logic [31:0]                r_result_nonce;
  logic [31:0]                r_result_cycles;

  // split results, computed straight from the offered job
  logic [32:0]                w_span;
  logic [32:0]                w_chunk;
  logic                       w_range_error;
  logic                       w_small_range;
  logic [31:0]                w_start [NUM_CORES];
  logic [31:0]                w_max   [NUM_CORES];
  logic [NUM_CORES-1:0]       w_used;

  logic                       w_job_fire;
  logic                       w_hit;
  logic [31:0]                w_hit_nonce;
  logic                       w_all_done;
  logic [31:0]                w_cycles_next;
  logic                       w_unused;

  // Cores store the nonce field little-endian, so the numeric start nonce is
  // byte-swapped into the low word of each core's block tail.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // The host may only hand over a job once every core has stopped.
  assign o_job_ready = (r_state == S_IDLE) && (i_core_running == '0);
  assign w_job_fire  = i_job_valid && o_job_ready;

  // The low word of the block tail is always replaced per core, and the chunk
  // never needs its top bit once it is divided by two or more cores.
  assign w_unused = ^{i_job_second_block[31:0], w_chunk[32]};

  // Divide the inclusive nonce range into equal chunks; the last core absorbs
  // the remainder, and tiny ranges go entirely to core 0.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // otherwise synthesis infers a latch to hold the old value.
    w_span        = {1'b0, i_job_nonce_hi} - {1'b0, i_job_nonce_lo} + 33'd1;
    w_chunk       = w_span >> LOG2_CORES;
    w_range_error = (i_job_nonce_hi < i_job_nonce_lo);
    w_small_range = (w_span < CORES_33);
    w_used        = '1;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_start[i] = i_job_nonce_lo + w_chunk[31:0] * 32'(i);
      w_max[i]   = w_start[i] + w_chunk[31:0] - 32'd1;
    end
    w_max[NUM_CORES-1] = i_job_nonce_hi;

    if (w_small_range) begin
      w_used    = '0;
      w_used[0] = 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        w_start[i] = '0;
        w_max[i]   = '0;
      end
      w_start[0] = i_job_nonce_lo;
      w_max[0]   = i_job_nonce_hi;
    end

    if (w_range_error) begin
      w_used = '0;
    end
  end

  // Find the lowest-index used core that has stopped with a winning nonce,
  // and whether every used core has stopped.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_used[i] && !i_core_running[i] && i_core_found[i]) begin
        w_hit       = 1'b1;
        w_hit_nonce = i_core_nonce[i*32 +: 32];
      end
    end
    w_all_done = ((i_core_running & r_used) == '0);
  end

  // The cycle count saturates instead of wrapping on a very long search.
  assign w_cycles_next = (r_result_cycles == 32'hFFFF_FFFF) ? r_result_cycles
                                                            : r_result_cycles + 32'd1;

  // Job control FSM: accept, launch, watch the cores, report, then drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values of the others, matching real flip-flops.
      r_state             <= S_IDLE;
      r_used              <= '0;
      r_hi                <= '0;
      r_core_start        <= '0;
      r_core_first_hash   <= '0;
      r_core_target       <= '0;
      r_core_second_block <= '0;
      r_core_max_nonce    <= '0;
      r_result_valid      <= 1'b0;
      r_result_found      <= 1'b0;
      r_result_aborted    <= 1'b0;
      r_result_error      <= 1'b0;
      r_result_nonce      <= '0;
      r_result_cycles     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_job_fire) begin
            r_used            <= w_used;
            r_hi              <= i_job_nonce_hi;
            r_core_first_hash <= i_job_first_hash;
            r_core_target     <= i_job_target;
            for (int i = 0; i < NUM_CORES; i++) begin
              r_core_second_block[i*128 +: 128] <= {i_job_second_block[127:32],
                                                    bswap32(w_start[i])};
              r_core_max_nonce[i*32 +: 32]      <= w_max[i];
            end
            r_result_cycles <= '0;
            if (w_range_error) begin
              // An inverted range is reported at once without touching a core.
              r_state          <= S_REPORT;
              r_result_valid   <= 1'b1;
              r_result_found   <= 1'b0;
              r_result_aborted <= 1'b0;
              r_result_error   <= 1'b1;
              r_result_nonce   <= '0;
            end else begin
              r_state      <= S_LAUNCH;
              r_core_start <= w_used;
            end
          end
        end

        S_LAUNCH: begin
          r_core_start    <= '0;
          r_result_cycles <= w_cycles_next;
          r_state         <= S_ARM;
        end

        S_ARM: begin
          // Cores are raising running now, so their status is not trusted yet.
          r_result_cycles <= w_cycles_next;
          if (i_abort) begin
            r_state          <= S_REPORT;
            r_result_valid   <= 1'b1;
            r_result_found   <= 1'b0;
            r_result_aborted <= 1'b1;
            r_result_error   <= 1'b0;
            r_result_nonce   <= '0;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_result_cycles <= w_cycles_next;
          if (w_hit) begin
            // A winner beats an abort arriving in the same cycle.
            r_state          <= S_REPORT;
            r_result_valid   <= 1'b1;
            r_result_found   <= 1'b1;
            r_result_aborted <= 1'b0;
            r_result_error   <= 1'b0;
            r_result_nonce   <= w_hit_nonce;
          end else if (i_abort) begin
            r_state          <= S_REPORT;
            r_result_valid   <= 1'b1;
            r_result_found   <= 1'b0;
            r_result_aborted <= 1'b1;
            r_result_error   <= 1'b0;
            r_result_nonce   <= '0;
          end else if (w_all_done) begin
            // Exhausted range: report the last nonce searched.
            r_state          <= S_REPORT;
            r_result_valid   <= 1'b1;
            r_result_found   <= 1'b0;
            r_result_aborted <= 1'b0;
            r_result_error   <= 1'b0;
            r_result_nonce   <= r_hi;
          end
        end

        S_REPORT: begin
          if (i_result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (i_core_running == '0) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_start        = r_core_start;
  assign o_core_first_hash   = r_core_first_hash;
  assign o_core_target       = r_core_target;
  assign o_core_second_block = r_core_second_block;
  assign o_core_max_nonce    = r_core_max_nonce;
  assign o_result_valid      = r_result_valid;
  assign o_result_found      = r_result_found;
  assign o_result_aborted    = r_result_aborted;
  assign o_result_error      = r_result_error;
  assign o_result_nonce      = r_result_nonce;
  assign o_result_cycles     = r_result_cycles;

endmodule

// File: doc/miner_dispatcher.md
# miner_dispatcher

Splits one mining job's nonce range across NUM_CORES `bitcoin_miner` cores, starts them together, and returns the first winning nonce or a not-found result. It sits between the host register interface and the array of miner cores. It owns the per-core job configuration registers, so the cores need no extra logic. Cores have no stop input, so the dispatcher drains them before it accepts the next job.

## Interface
- NUM_CORES, 4, number of miner cores; power of two, 1..16
- clk  in  1  rising-edge clock shared with all cores
- rst  in  1  synchronous active-high reset
- job_valid  in  1  host offers a job
- job_ready  out  1  dispatcher accepts the job when both job_valid and job_ready are high
- job_first_hash  in  256  midstate of the first block, broadcast to all cores
- job_second_block  in  128  block tail; bits [31:0] are ignored and replaced per core
- job_target  in  256  target, broadcast to all cores
- job_nonce_lo / job_nonce_hi  in  32 each  inclusive numeric (big-endian) nonce range
- abort  in  1  host abandons the current job
- core_start  out  NUM_CORES  one-cycle start pulse per core
- core_first_hash / core_target  out  256  registered job fields
- core_second_block  out  NUM_CORES*128  per-core block; [31:0] holds the byte-swapped core start nonce
- core_max_nonce  out  NUM_CORES*32  inclusive numeric end nonce per core
- core_running / core_found  in  NUM_CORES each  core status
- core_nonce  in  NUM_CORES*32  core nonce outputs
- result_valid  out  1  result offered
- result_ready  in  1  host takes the result
- result_found / result_aborted / result_error  out  1 each  outcome flags
- result_nonce  out  32  winning nonce (numeric)
- result_cycles  out  32  cycles from LAUNCH to result; saturates at 0xFFFFFFFF

## Operation
- States: IDLE, LAUNCH, ARM, RUN, REPORT, DRAIN.
- IDLE
  - job_ready = (state==IDLE) && (core_running==0).
  - On handshake: register all job fields and compute the split.
  - span = hi - lo + 1, computed in 33 bits.
  - chunk = span >> log2(NUM_CORES).
  - Core i gets start = lo + i*chunk and max = start + chunk - 1.
  - The last core's max is forced to hi.
  - If span < NUM_CORES: core 0 gets the full range and no other core is started.
  - If hi < lo: no core is started; go directly to REPORT with error=1, found=0.
  - Otherwise go to LAUNCH.
- LAUNCH
  - One cycle.
  - core_start is high for each used core.
  - result_cycles clears to 0.
- ARM
  - One cycle.
  - Cores raise running in this cycle; the dispatcher does not evaluate done here.
- RUN
  - A used core is done when core_running[i]==0.
  - If any done core has core_found[i]=1:
    - capture the lowest-index such core's core_nonce;
    - set found=1;
    - go to REPORT.
  - Else, if all used cores are done: found=0, nonce = hi, go to REPORT.
  - abort in ARM or RUN: aborted=1, found=0, go to REPORT.
  - A found result takes priority over abort in the same cycle.
- REPORT
  - result_valid is high and all result fields are stable.
  - On result_ready: go to DRAIN.
- DRAIN
  - Wait until core_running==0, then go to IDLE.
  - Cores always stop on their own, at found or at max_nonce.
- Core config outputs hold their values from LAUNCH until the next job handshake.
- result_cycles increments every cycle in LAUNCH, ARM and RUN.
- All additions are modulo 2^32, except span, which is 33 bits.
- The full range 0..0xFFFFFFFF gives span = 2^32 and chunk = 2^32/NUM_CORES.

## Timing
- Reset values:
  - state IDLE;
  - core_start, result_valid, result_found, result_aborted and result_error all 0;
  - result_nonce and result_cycles 0;
  - core config registers 0.
- Reset mid-job:
  - the dispatcher returns to IDLE;
  - running cores are not stopped;
  - job_ready stays low until core_running==0.
- Job handshake to core_start: 1 cycle (the LAUNCH cycle).
- Found detection: core_running[i] low at edge N gives result_valid high at edge N+1.
- result_valid, once high, holds until the result_ready handshake. Its fields do not change while it is high.
- core_start is never asserted to a core whose core_running is high.

## Test plan
- NUM_CORES=4, lo=0, hi=0x3FF, model cores:
  - required split: 0..0xFF, 0x100..0x1FF, 0x200..0x2FF, 0x300..0x3FF;
  - core 2 finds 0x2A7 → result_found=1, result_nonce=0x2A7;
  - no result_valid before the drain completes is not required; DRAIN then waits for all cores.
- Cores 1 and 3 finish with found=1 in the same cycle → result_nonce is core 1's nonce.
- No core finds → result_found=0, result_nonce=hi, result_valid exactly once.
- Degenerate ranges:
  - hi=5, lo=9 → result_error=1 with no core_start pulse;
  - lo=hi=7 → only core 0 is started, with start 7 and max 7.
- Full range 0..0xFFFFFFFF → core 3 max=0xFFFFFFFF and core 1 start=0x40000000. Check the byte-swapped second_block[31:0]=0x00000040.
- Control corner cases:
  - abort during RUN → result_aborted=1, then job_ready stays low until the model cores drop running;
  - rst during RUN → all outputs at reset values on the next cycle.
